alu_issue: RTL and testbench

Sequencing front end for the single-cycle 32-bit ALU. It accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives one command at a time onto the ALU's control and operand inputs, samples the ALU's result and flags one cycle later, and returns them with a sequence tag over a second valid/ready stream. It sits between the datapath or test sequencer and the ALU, and is the initiator for the ALU's combinational responder interface.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_issue.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue front end: control codes, FSM state encoding, tag width.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_EQL = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int TAG_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Single-clock command FIFO holding packed {ctl, a, b, tag} entries; DEPTH must be a power of 2.
module alu_cmd_fifo #(
  parameter int WIDTH = 76,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Full is taken from the registered count, so a pop on a full queue never frees room that cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is not reset; only pointers and count are, so no entry is visible until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Sequencer that queues ALU commands, drives them one at a time and returns tagged results.
// Defining ALU_CHECK_EN adds a golden model and the chk_mismatch/chk_count ports.
module alu_issue
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_ctl,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic [3:0]       alu_ctl,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_out,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             ovf_sticky,
  input  logic             clr_sticky
`ifdef ALU_CHECK_EN
  ,
  output logic             chk_mismatch,
  output logic [7:0]       chk_count
`endif
);

  localparam int ENTRY_W = 4 + 2*W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               accept;
  logic               pop;
  logic               capture;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [3:0]         drv_ctl_q;
  logic [W-1:0]       drv_a_q, drv_b_q;
  logic [TAG_W-1:0]   drv_tag_q;
  logic [W-1:0]       rsp_out_q;
  logic               rsp_zero_q, rsp_ovf_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               ovf_sticky_q;

  assign cmd_ready = (fifo_count != CNT_W'(DEPTH));
  assign accept    = cmd_valid && !fifo_full;

  alu_cmd_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata ({cmd_ctl, cmd_a, cmd_b, tag_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          pop     = !fifo_empty;
          state_d = fifo_empty ? ST_IDLE : ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      drv_ctl_q    <= '0;
      drv_a_q      <= '0;
      drv_b_q      <= '0;
      drv_tag_q    <= '0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_tag_q    <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) tag_q <= tag_q + 1'b1;
      if (pop) {drv_ctl_q, drv_a_q, drv_b_q, drv_tag_q} <= fifo_rdata;
      if (capture) begin
        rsp_out_q  <= alu_out;
        rsp_zero_q <= alu_zero;
        rsp_ovf_q  <= alu_overflow;
        rsp_tag_q  <= drv_tag_q;
      end
      // A fresh overflow outranks a clear arriving on the same edge.
      if (capture && alu_overflow) ovf_sticky_q <= 1'b1;
      else if (clr_sticky)         ovf_sticky_q <= 1'b0;
    end
  end

  assign alu_ctl      = drv_ctl_q;
  assign alu_a        = drv_a_q;
  assign alu_b        = drv_b_q;
  assign rsp_valid    = (state_q == ST_HOLD);
  assign rsp_out      = rsp_out_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_tag      = rsp_tag_q;
  assign ovf_sticky   = ovf_sticky_q;

`ifdef ALU_CHECK_EN
  logic [W-1:0] gold_sum, gold_diff, gold_out;
  logic         gold_ovf;
  logic         mismatch;
  logic         chk_mismatch_q;
  logic [7:0]   chk_count_q;

  assign gold_sum  = drv_a_q + drv_b_q;
  assign gold_diff = drv_a_q - drv_b_q;

  always_comb begin
    gold_out = '0;
    gold_ovf = 1'b0;
    case (drv_ctl_q)
      ALU_AND: gold_out = drv_a_q & drv_b_q;
      ALU_OR:  gold_out = drv_a_q | drv_b_q;
      ALU_NOR: gold_out = ~(drv_a_q | drv_b_q);
      ALU_EQL: gold_out = {{(W-1){1'b0}}, (drv_a_q == drv_b_q)};
      ALU_ADD: begin
        gold_out = gold_sum;
        gold_ovf = (drv_a_q[W-1] == drv_b_q[W-1]) && (gold_sum[W-1] != drv_a_q[W-1]);
      end
      ALU_SUB: begin
        gold_out = gold_diff;
        gold_ovf = (drv_a_q[W-1] != drv_b_q[W-1]) && (gold_diff[W-1] != drv_a_q[W-1]);
      end
      default: ;
    endcase
  end

  assign mismatch = capture &&
    ({alu_out, alu_zero, alu_overflow} != {gold_out, (gold_out == '0), gold_ovf});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_mismatch_q <= 1'b0;
      chk_count_q    <= '0;
    end else begin
      chk_mismatch_q <= mismatch;
      if (mismatch && chk_count_q != 8'hFF) chk_count_q <= chk_count_q + 1'b1;
    end
  end

  assign chk_mismatch = chk_mismatch_q;
  assign chk_count    = chk_count_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU stub, response scoreboard and vector table.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
    logic [7:0]   tag;
  } exp_t;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_ctl = '0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_zero, alu_overflow;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_out;
  logic         rsp_zero, rsp_overflow;
  logic [7:0]   rsp_tag;
  logic         ovf_sticky;
  logic         clr_sticky = 1'b0;
`ifdef ALU_CHECK_EN
  logic         chk_mismatch;
  logic [7:0]   chk_count;
  int           chk_pulses = 0;
`endif

  logic         or_fault = 1'b0;
  logic [W-1:0] stub_sum, stub_diff;
  exp_t         sb_q[$];
  exp_t         drv_exp = '0;
  exp_t         mon_got;
  logic [7:0]   tag_model = '0;
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  int           rsp_seen = 0;
  int           rsp_cycles[$];
  vec_t         vecs[12];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_issue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ctl      (cmd_ctl),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_ctl      (alu_ctl),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_tag      (rsp_tag),
    .ovf_sticky   (ovf_sticky),
    .clr_sticky   (clr_sticky)
`ifdef ALU_CHECK_EN
    ,
    .chk_mismatch (chk_mismatch),
    .chk_count    (chk_count)
`endif
  );

  // Combinational ALU responder; or_fault corrupts bit 0 of OR results.
  assign stub_sum  = alu_a + alu_b;
  assign stub_diff = alu_a - alu_b;
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_ctl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = (alu_a | alu_b) ^ {{(W-1){1'b0}}, or_fault};
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_EQL: alu_out = (alu_a == alu_b) ? 32'd1 : 32'd0;
      ALU_ADD: begin
        alu_out      = stub_sum;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (stub_sum[W-1] != alu_a[W-1]);
      end
      ALU_SUB: begin
        alu_out      = stub_diff;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (stub_diff[W-1] != alu_a[W-1]);
      end
      default: ;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back('{out: drv_exp.out, zero: drv_exp.zero, ovf: drv_exp.ovf, tag: tag_model});
        tag_model = tag_model + 8'd1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        rsp_cycles.push_back(cycle);
        mon_got = '{out: rsp_out, zero: rsp_zero, ovf: rsp_overflow, tag: rsp_tag};
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got tag %0h out %0h, expected no response", rsp_tag, rsp_out);
        end else begin
          check("rsp", mon_got, sb_q.pop_front());
        end
      end
`ifdef ALU_CHECK_EN
      if (chk_mismatch) chk_pulses++;
`endif
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    rsp_ready  = 1'b0;
    clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    tag_model = '0;
    rst_n     = 1'b1;
  endtask

  task automatic send(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eo, input logic ez, input logic eov,
                      input int budget, output bit ok);
    cmd_valid = 1'b1;
    cmd_ctl   = ctl;
    cmd_a     = a;
    cmd_b     = b;
    drv_exp   = '{out: eo, zero: ez, ovf: eov, tag: 8'h00};
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_must(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eo, input logic ez, input logic eov);
    bit ok;
    send(ctl, a, b, eo, ez, eov, 50, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ctl %0h not accepted within 50 cycles", ctl);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int accepted;
    int seen0;

    vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{ALU_SUB, 32'h80F04021, 32'h80F04021, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{ALU_EQL, 32'h80F04021, 32'h80F04021, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{ALU_EQL, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{ALU_AND, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{ALU_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7]  = '{ALU_NOR, 32'hFFFF0000, 32'h0000FF00, 32'h000000FF, 1'b0, 1'b0};
    vecs[8]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{ALU_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[10] = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{4'b0011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};

    // Reset values
    do_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bundle", {rsp_out, rsp_zero, rsp_overflow, rsp_tag}, 0);
    check("rst_alu_ctl", alu_ctl, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
`ifdef ALU_CHECK_EN
    check("rst_chk_mismatch", chk_mismatch, 0);
    check("rst_chk_count", chk_count, 0);
`endif

    // Latency from an empty pipeline, and response stability while stalled
    send_must(ALU_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_k_valid", rsp_valid, 0);
    check("lat_k_alu_ctl", alu_ctl, 0);
    @(negedge clk);
    check("lat_k1_alu_ctl", alu_ctl, ALU_ADD);
    check("lat_k1_valid", rsp_valid, 0);
    @(negedge clk);
    check("lat_k2_valid", rsp_valid, 1);
    repeat (3) @(negedge clk);
    check("hold_stable_out", rsp_out, 8);
    check("hold_stable_valid", rsp_valid, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain(20);

    // Table-driven vectors
    for (int i = 0; i < 12; i++)
      send_must(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].zero, vecs[i].ovf);
    drain(100);
    check("tbl_sticky", ovf_sticky, 1);
    check("idle_alu_ctl_kept", alu_ctl, 4'b0011);
    check("idle_alu_a_kept", alu_a, 32'd5);

    // Clear on the edge before capture, clear together with a new overflow on the capture edge
    send_must(ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("sticky_cleared", ovf_sticky, 0);
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", ovf_sticky, 1);
    drain(20);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    check("sticky_clear_alone", ovf_sticky, 0);

    // Capacity: one held response plus DEPTH queued, then drain at full rate
    do_reset();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      send(ALU_ADD, i, i << 4, i * 17, (i == 0), 1'b0, 8, ok);
      if (ok) accepted++;
    end
    check("cap_accepted", accepted, 5);
    @(negedge clk);
    check("cap_cmd_ready_low", cmd_ready, 0);
    rsp_cycles.delete();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain(40);
    check("cap_rsp_count", rsp_cycles.size(), 5);
    for (int i = 1; i < rsp_cycles.size(); i++)
      check($sformatf("cap_spacing_%0d", i), rsp_cycles[i] - rsp_cycles[i-1], 2);

    // Tag wrap across 258 commands
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 258; i++)
      send_must(ALU_ADD, i, 32'h10000000, i + 32'h10000000, 1'b0, 1'b0);
    drain(100);
    check("wrap_last_tag", rsp_tag, 8'd1);

    // Reset while holding a response with three commands queued
    do_reset();
    send_must(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      send_must(ALU_OR, i, 32'h100, i | 32'h100, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("mid_hold_valid", rsp_valid, 1);
    check("mid_sticky_before", ovf_sticky, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_bundle", {rsp_out, rsp_zero, rsp_overflow, rsp_tag}, 0);
    check("mid_rst_alu_ctl", alu_ctl, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    sb_q.delete();
    tag_model = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen0 = rsp_seen;
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_replay", rsp_seen - seen0, 0);
    check("mid_idle_valid", rsp_valid, 0);

`ifdef ALU_CHECK_EN
    // Faulty OR responder: one mismatch pulse per OR
    do_reset();
    or_fault = 1'b1;
    rsp_ready = 1'b1;
    chk_pulses = 0;
    send_must(ALU_OR,  32'h10, 32'h01, 32'h10, 1'b0, 1'b0);
    send_must(ALU_ADD, 32'h2,  32'h2,  32'h4,  1'b0, 1'b0);
    send_must(ALU_OR,  32'h0,  32'h0,  32'h1,  1'b0, 1'b0);
    send_must(ALU_ADD, 32'h3,  32'h4,  32'h7,  1'b0, 1'b0);
    send_must(ALU_OR,  32'hF0, 32'h0F, 32'hFE, 1'b0, 1'b0);
    drain(40);
    check("chk_pulses_faulty", chk_pulses, 3);
    check("chk_count_faulty", chk_count, 3);
    or_fault = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    chk_pulses = 0;
    for (int i = 0; i < 12; i++)
      send_must(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].zero, vecs[i].ovf);
    drain(100);
    check("chk_pulses_clean", chk_pulses, 0);
    check("chk_count_clean", chk_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
